// File: rtl/risc_pkg.sv
// Shared definitions for the small RISC core: instruction field positions, opcode classes,
// and the sequencer state encoding. Also used by the ALU.
package risc_pkg;

    localparam int unsigned InstrW   = 20;
    localparam int unsigned PcW      = 8;
    localparam int unsigned RegAddrW = 3;
    localparam int unsigned DataW    = 16;
    localparam int unsigned AluResW  = 18;

    localparam int unsigned OpMsb    = 19;
    localparam int unsigned OpLsb    = 16;
    localparam int unsigned AluOpMsb = 19;
    localparam int unsigned AluOpLsb = 15;
    localparam int unsigned RdMsb    = 14;
    localparam int unsigned RdLsb    = 12;
    localparam int unsigned RaMsb    = 11;
    localparam int unsigned RaLsb    = 9;
    localparam int unsigned RbMsb    = 8;
    localparam int unsigned RbLsb    = 6;
    localparam int unsigned ImmMsb   = 8;
    localparam int unsigned ImmLsb   = 0;

    typedef enum logic [3:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNop, OpNop2, OpIll7,
        OpShl, OpShr, OpSlt, OpLui, OpJumpA, OpJumpR, OpIll14, OpHalt
    } op_e;

    typedef enum logic [2:0] {
        ClsWrite, ClsNop, ClsJumpA, ClsJumpR, ClsIllegal, ClsHalt
    } op_class_e;

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StWb, StHalt
    } state_e;

    function automatic op_class_e decode_class(input logic [3:0] op);
        op_class_e cls;
        case (op)
            OpNop, OpNop2:   cls = ClsNop;
            OpIll7, OpIll14: cls = ClsIllegal;
            OpJumpA:         cls = ClsJumpA;
            OpJumpR:         cls = ClsJumpR;
            OpHalt:          cls = ClsHalt;
            default:         cls = ClsWrite;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction and opcode classification of a latched instruction word.
module instr_decode
    import risc_pkg::*;
(
    input  logic [InstrW-1:0]   instr_i,
    output logic [4:0]          aluopcode_o,
    output logic [RegAddrW-1:0] rd_o,
    output logic [RegAddrW-1:0] ra_o,
    output logic [RegAddrW-1:0] rb_o,
    output logic [8:0]          immed_o,
    output op_class_e           op_class_o
);

    // rb and immed share bits [8:6]; both views are always presented
    assign aluopcode_o = instr_i[AluOpMsb:AluOpLsb];
    assign rd_o        = instr_i[RdMsb:RdLsb];
    assign ra_o        = instr_i[RaMsb:RaLsb];
    assign rb_o        = instr_i[RbMsb:RbLsb];
    assign immed_o     = instr_i[ImmMsb:ImmLsb];
    assign op_class_o  = decode_class(instr_i[OpMsb:OpLsb]);

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetch, decode, execute, write-back; owns pc and
// the retired/halted/illegal status.
module ctrl_sequencer
    import risc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [PcW-1:0]       imem_addr,
    input  logic                 imem_valid,
    input  logic [InstrW-1:0]    imem_rdata,
    output logic                 alu_en,
    output logic [4:0]           aluopcode,
    output logic [8:0]           immed,
    output logic [RegAddrW-1:0]  rf_raddr_a,
    output logic [RegAddrW-1:0]  rf_raddr_b,
    output logic                 rf_we,
    output logic [RegAddrW-1:0]  rf_waddr,
    output logic [DataW-1:0]     rf_wdata,
    input  logic [AluResW-1:0]   alu_result,
    input  logic                 shldBranch,
    output logic [PcW-1:0]       pc,
    output logic                 halted,
    output logic                 illegal,
    output logic [15:0]          retired
);

    state_e              state_q, state_d;
    logic [PcW-1:0]      pc_q, pc_d;
    logic [InstrW-1:0]   instr_q, instr_d;
    logic [DataW-1:0]    wdata_q, wdata_d;
    logic                branch_q, branch_d;
    logic [15:0]         retired_q, retired_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;
    logic                imem_req_q, imem_req_d;
    logic                alu_en_q, alu_en_d;
    logic                rf_we_q, rf_we_d;

    logic [RegAddrW-1:0] dec_rd;
    op_class_e           dec_class;

    instr_decode u_instr_decode (
        .instr_i     (instr_q),
        .aluopcode_o (aluopcode),
        .rd_o        (dec_rd),
        .ra_o        (rf_raddr_a),
        .rb_o        (rf_raddr_b),
        .immed_o     (immed),
        .op_class_o  (dec_class)
    );

    // The ALU result's top two bits carry flags that write-back does not use
    logic unused_alu_hi;
    assign unused_alu_hi = ^alu_result[AluResW-1:DataW];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        wdata_d   = wdata_q;
        branch_d  = branch_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        halted_d  = halted_q;

        unique case (state_q)
            StFetch: begin
                // Only accept a word once the request has actually been presented
                if (imem_req_q && imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (dec_class)
                    ClsHalt:    state_d = StHalt;
                    ClsNop:     state_d = StWb;
                    ClsIllegal: begin
                        state_d   = StWb;
                        illegal_d = 1'b1;
                    end
                    default:    state_d = StExec;
                endcase
            end
            StExec: begin
                wdata_d  = alu_result[DataW-1:0];
                branch_d = shldBranch;
                state_d  = StWb;
            end
            StWb: begin
                if (retired_q != 16'hFFFF) begin
                    retired_d = retired_q + 16'd1;
                end
                if (dec_class == ClsJumpA || (dec_class == ClsJumpR && branch_q)) begin
                    pc_d = wdata_q[PcW-1:0];
                end else begin
                    pc_d = pc_q + 8'd1;
                end
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (state_d == StHalt) begin
            halted_d = 1'b1;
        end

        // Registered strobes follow the state being entered, so they align with state_q
        imem_req_d = (state_d == StFetch);
        alu_en_d   = (state_d == StExec);
        rf_we_d    = (state_d == StWb) && (dec_class == ClsWrite);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= '0;
            instr_q    <= '0;
            wdata_q    <= '0;
            branch_q   <= 1'b0;
            retired_q  <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            imem_req_q <= 1'b0;
            alu_en_q   <= 1'b0;
            rf_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            wdata_q    <= wdata_d;
            branch_q   <= branch_d;
            retired_q  <= retired_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
            imem_req_q <= imem_req_d;
            alu_en_q   <= alu_en_d;
            rf_we_q    <= rf_we_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign alu_en    = alu_en_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = dec_rd;
    assign rf_wdata  = wdata_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer with hand-computed expectations.
module tb_ctrl_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [19:0] imem_rdata;
    logic        alu_en;
    logic [4:0]  aluopcode;
    logic [8:0]  immed;
    logic [2:0]  rf_raddr_a;
    logic [2:0]  rf_raddr_b;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [17:0] alu_result;
    logic        shldBranch;
    logic [7:0]  pc;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;

    ctrl_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .alu_en     (alu_en),
        .aluopcode  (aluopcode),
        .immed      (immed),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .alu_result (alu_result),
        .shldBranch (shldBranch),
        .pc         (pc),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    int          obs_cyc;
    int          obs_alu;
    int          obs_we;
    logic [2:0]  obs_waddr;
    logic [15:0] obs_wdata;
    logic        obs_we_follow;
    logic [4:0]  obs_aluop;
    logic [8:0]  obs_immed;
    logic [2:0]  obs_ra;
    logic [2:0]  obs_rb;
    logic        obs_req_held;
    logic        excl_bad = 1'b0;
    logic        hold_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic note_excl();
        if (int'(alu_en) + int'(rf_we) + int'(imem_req) > 1) excl_bad = 1'b1;
    endtask

    // Starts in a FETCH cycle with imem_req high; returns at the next FETCH or at HALT
    task automatic run_instr(input logic [19:0] word, input logic [17:0] res, input logic br,
                             input int waits);
        logic prev_alu;
        obs_cyc = 0; obs_alu = 0; obs_we = 0; obs_we_follow = 1'b0; obs_req_held = 1'b1;
        obs_waddr = '0; obs_wdata = '0; obs_aluop = '0; obs_immed = '0; obs_ra = '0; obs_rb = '0;
        prev_alu = 1'b0;
        alu_result = res;
        shldBranch = br;
        for (int w = 0; w < waits; w++) begin
            imem_valid = 1'b0;
            imem_rdata = word;
            if (!imem_req) obs_req_held = 1'b0;
            note_excl();
            step();
            obs_cyc++;
        end
        if (!imem_req) obs_req_held = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = word;
        step();
        obs_cyc++;
        // Keep a HALT-looking strobe alive outside FETCH; it must be ignored
        imem_rdata = 20'hFFFFF;
        while (obs_cyc < 30) begin
            note_excl();
            if (imem_req || halted) break;
            if (alu_en) begin
                obs_alu++;
                obs_aluop = aluopcode;
                obs_immed = immed;
                obs_ra    = rf_raddr_a;
                obs_rb    = rf_raddr_b;
            end
            if (rf_we) begin
                obs_we++;
                obs_waddr = rf_waddr;
                obs_wdata = rf_wdata;
                if (prev_alu) obs_we_follow = 1'b1;
            end
            prev_alu = alu_en;
            step();
            obs_cyc++;
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 20'hFFFFF;
        alu_result = 18'h3FFFF;
        shldBranch = 1'b1;
        step();
        step();
        check("rst_pc", pc, 8'h00);
        check("rst_req", imem_req, 1'b0);
        check("rst_alu_en", alu_en, 1'b0);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_retired", retired, 16'h0000);
        check("rst_waddr", rf_waddr, 3'd0);
        check("rst_wdata", rf_wdata, 16'h0000);
        check("rst_aluop", aluopcode, 5'd0);

        rst = 1'b0;
        step();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 8'h00);

        run_instr(20'h01000, 18'h00005, 1'b0, 0);
        check("add_cycles", obs_cyc, 4);
        check("add_alu_cnt", obs_alu, 1);
        check("add_we_cnt", obs_we, 1);
        check("add_we_after_alu", obs_we_follow, 1'b1);
        check("add_waddr", obs_waddr, 3'd1);
        check("add_wdata", obs_wdata, 16'h0005);
        check("add_pc", pc, 8'h01);
        check("add_retired", retired, 16'd1);

        run_instr(20'h8D7AD, 18'h3BEEF, 1'b0, 0);
        check("fld_aluop", obs_aluop, 5'h11);
        check("fld_immed", obs_immed, 9'h1AD);
        check("fld_ra", obs_ra, 3'd3);
        check("fld_rb", obs_rb, 3'd6);
        check("fld_waddr", obs_waddr, 3'd5);
        check("fld_wdata", obs_wdata, 16'hBEEF);
        check("fld_pc", pc, 8'h02);

        run_instr(20'hC0000, 18'h00042, 1'b0, 0);
        check("ja_we_cnt", obs_we, 0);
        check("ja_alu_cnt", obs_alu, 1);
        check("ja_cycles", obs_cyc, 4);
        check("ja_addr", imem_addr, 8'h42);

        run_instr(20'hC0000, 18'h00010, 1'b0, 0);
        check("ja10_pc", pc, 8'h10);

        run_instr(20'hD0000, 18'h00099, 1'b0, 0);
        check("jr_nt_pc", pc, 8'h11);
        check("jr_nt_we_cnt", obs_we, 0);

        run_instr(20'hD0000, 18'h00020, 1'b1, 0);
        check("jr_t_pc", pc, 8'h20);

        run_instr(20'h01000, 18'h00007, 1'b0, 3);
        check("wait_cycles", obs_cyc, 7);
        check("wait_req_held", obs_req_held, 1'b1);
        check("wait_wdata", obs_wdata, 16'h0007);
        check("wait_pc", pc, 8'h21);

        run_instr(20'hC0000, 18'h000FF, 1'b0, 0);
        check("jff_pc", pc, 8'hFF);
        check("pre_illegal", illegal, 1'b0);

        run_instr(20'h50000, 18'h00033, 1'b0, 0);
        check("nop_cycles", obs_cyc, 3);
        check("nop_alu_cnt", obs_alu, 0);
        check("nop_we_cnt", obs_we, 0);
        check("nop_wrap_pc", pc, 8'h00);

        run_instr(20'hE0000, 18'h00044, 1'b0, 0);
        check("ill_flag", illegal, 1'b1);
        check("ill_alu_cnt", obs_alu, 0);
        check("ill_we_cnt", obs_we, 0);
        check("ill_cycles", obs_cyc, 3);
        check("ill_pc", pc, 8'h01);
        check("ill_retired", retired, 16'd10);

        // Reset arriving at the edge that ends EXEC
        alu_result = 18'h00009;
        shldBranch = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 20'h01000;
        step();
        imem_rdata = 20'hFFFFF;
        step();
        check("rx_alu_en", alu_en, 1'b1);
        rst = 1'b1;
        imem_valid = 1'b0;
        step();
        check("rx_rf_we", rf_we, 1'b0);
        check("rx_pc", pc, 8'h00);
        check("rx_req", imem_req, 1'b0);
        check("rx_illegal", illegal, 1'b0);
        check("rx_retired", retired, 16'd0);
        rst = 1'b0;
        step();
        check("rx_rf_we_after", rf_we, 1'b0);
        check("rx_refetch_req", imem_req, 1'b1);
        check("rx_refetch_addr", imem_addr, 8'h00);

        run_instr(20'hF0000, 18'h00001, 1'b0, 0);
        check("halt_flag", halted, 1'b1);
        check("halt_cycles", obs_cyc, 2);
        check("halt_alu_cnt", obs_alu, 0);
        check("halt_retired", retired, 16'd0);
        hold_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (imem_req || alu_en || rf_we || !halted) hold_bad = 1'b1;
        end
        imem_valid = 1'b0;
        check("halt_hold", hold_bad, 1'b0);
        check("halt_pc", pc, 8'h00);
        check("strobe_exclusive", excl_bad, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
